// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle, then a single sign-fixup cycle before writing HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             abort,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state_q;
    logic               isDiv_q;
    logic               negRes_q;
    logic               negRem_q;
    logic               divZero_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               isSigned;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mulRes;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    // Signed ops work on magnitudes; the sign flags are reapplied in FIX.
    assign isSigned = ~op[0];
    assign signA    = isSigned & operandA[WIDTH-1];
    assign signB    = isSigned & operandB[WIDTH-1];
    assign magA     = signA ? -operandA : operandA;
    assign magB     = signB ? -operandB : operandB;

    // prod_q holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        addSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        remShift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        diff     = remShift - {1'b0, opnd_q};
        prod_d   = prod_q;
        if (isDiv_q) begin
            if (diff[WIDTH]) begin
                prod_d = {remShift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end else begin
                prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (prod_q[0]) begin
                addSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
            end
            prod_d = {addSum, prod_q[WIDTH-1:1]};
        end
    end

    // A zero divisor leaves an all-ones quotient, which must not be negated.
    assign mulRes  = negRes_q ? -prod_q : prod_q;
    assign quot    = prod_q[WIDTH-1:0];
    assign rem     = prod_q[2*WIDTH-1:WIDTH];
    assign quotFix = (negRes_q & ~divZero_q) ? -quot : quot;
    assign remFix  = negRem_q ? -rem : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            opnd_q    <= '0;
            prod_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hiWrite) hi_q <= writeData;
                    if (loWrite) lo_q <= writeData;
                    if (start && !abort) begin
                        isDiv_q   <= op[1];
                        negRes_q  <= signA ^ signB;
                        negRem_q  <= signA;
                        divZero_q <= (operandB == '0);
                        opnd_q    <= op[1] ? magB : magA;
                        prod_q    <= op[1] ? {{WIDTH{1'b0}}, magA} : {{WIDTH{1'b0}}, magB};
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        prod_q  <= prod_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST) state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!abort) begin
                        done_q <= 1'b1;
                        if (isDiv_q) begin
                            hi_q <= remFix;
                            lo_q <= quotFix;
                        end else begin
                            hi_q <= mulRes[2*WIDTH-1:WIDTH];
                            lo_q <= mulRes[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency,
// abort, MTHI/MTLO, back-to-back issue and asynchronous reset.
module tb_mult_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        abort;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .abort     (abort),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench one unit after the launch edge, i.e. in busy cycle 1.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        tick(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int alreadyBusy,
                            input logic [31:0] expHi, input logic [31:0] expLo);
        int n;
        n = alreadyBusy;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
        checkOutput({tag, "_busyCycles"}, 32'(n), 32'd33);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
    endtask

    initial begin
        bit sawDone;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        op          = MULT;
        operandA    = '0;
        operandB    = '0;
        abort       = 1'b0;
        hiWrite     = 1'b0;
        loWrite     = 1'b0;
        writeData   = '0;

        tick(1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        reset = 1'b0;
        tick(1);

        applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multuMax", 0, 32'hFFFF_FFFE, 32'h0000_0001);
        tick(1);
        checkOutput("multuMax_donePulse", 32'(done), 32'd0);

        applyStimulus(MULT, 32'hFFFF_FFFD, 32'd7);
        waitDone("multNeg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        applyStimulus(MULT, 32'h8000_0000, 32'h8000_0000);
        waitDone("multMinSq", 0, 32'h4000_0000, 32'h0000_0000);

        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("divNeg7by2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus(DIVU, 32'd100, 32'd0);
        waitDone("divuByZero", 0, 32'd100, 32'hFFFF_FFFF);

        applyStimulus(DIV, 32'hFFFF_FF9C, 32'd0);
        waitDone("divByZero", 0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("divOverflow", 0, 32'h0000_0000, 32'h8000_0000);

        // A second start during busy must not disturb the running DIVU.
        applyStimulus(DIVU, 32'd50, 32'd7);
        tick(4);
        start    = 1'b1;
        op       = MULTU;
        operandA = 32'd3;
        operandB = 32'd3;
        tick(1);
        start = 1'b0;
        waitDone("startWhileBusy", 5, 32'd1, 32'd7);

        applyStimulus(DIV, 32'd7, 32'hFFFF_FFFE);
        waitDone("div7byNeg2", 0, 32'd1, 32'hFFFF_FFFD);

        applyStimulus(DIVU, 32'd50, 32'd7);
        tick(9);
        abort    = 1'b1;
        start    = 1'b1;
        op       = MULTU;
        operandA = 32'd9;
        operandB = 32'd9;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_hi", hi, 32'd1);
        checkOutput("abort_lo", lo, 32'hFFFF_FFFD);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
            tick(1);
        end
        checkOutput("abort_noLaterActivity", 32'(sawDone), 32'd0);
        checkOutput("abort_hiKept", hi, 32'd1);

        abort = 1'b1;
        start = 1'b1;
        op    = MULTU;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("idleAbortStart_busy", 32'(busy), 32'd0);

        hiWrite   = 1'b1;
        loWrite   = 1'b1;
        writeData = 32'h0000_CAFE;
        tick(1);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        checkOutput("mtBoth_hi", hi, 32'h0000_CAFE);
        checkOutput("mtBoth_lo", lo, 32'h0000_CAFE);

        hiWrite   = 1'b1;
        writeData = 32'h0000_1234;
        tick(1);
        hiWrite   = 1'b0;
        loWrite   = 1'b1;
        writeData = 32'h0000_5678;
        tick(1);
        loWrite = 1'b0;
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        checkOutput("mtlo_lo", lo, 32'h0000_5678);

        // MT strobes while busy are dropped; completion then overwrites HI/LO.
        applyStimulus(MULTU, 32'd3, 32'd5);
        tick(2);
        hiWrite   = 1'b1;
        loWrite   = 1'b1;
        writeData = 32'h0000_DEAD;
        tick(1);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        checkOutput("mtBusy_hi", hi, 32'h0000_1234);
        checkOutput("mtBusy_lo", lo, 32'h0000_5678);
        waitDone("mtBusyOp", 3, 32'd0, 32'd15);

        // Issue on the done cycle, with an MTHI on the same edge as start.
        hiWrite   = 1'b1;
        writeData = 32'h0000_7777;
        applyStimulus(MULTU, 32'd6, 32'd7);
        hiWrite = 1'b0;
        checkOutput("backToBack_busy", 32'(busy), 32'd1);
        checkOutput("mtWithStart_hi", hi, 32'h0000_7777);
        waitDone("backToBack", 0, 32'd0, 32'd42);

        applyStimulus(MULT, 32'd5, 32'd6);
        tick(14);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncRst_busy", 32'(busy), 32'd0);
        checkOutput("asyncRst_done", 32'(done), 32'd0);
        checkOutput("asyncRst_hi", hi, 32'h0);
        checkOutput("asyncRst_lo", lo, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        applyStimulus(MULT, 32'hFFFF_FFFB, 32'd6);
        waitDone("afterRst", 0, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
